// File: rtl/sram_prog_loader.sv
// sram_prog_loader: read-only sequencer for the external asynchronous program
// SRAM. A start pulse reads a contiguous block of words, each access held for
// WAIT_CYCLES+1 cycles, and streams the words out through a small FIFO with a
// valid/ready handshake. The loader owns every SRAM control pin.
module sram_prog_loader #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ce_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_STALL  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  // Sequencer state
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [3:0]        wait_q, wait_d;

  // Registered status / pin outputs
  logic busy_q, done_q, ctrl_n_q;

  // Output FIFO storage
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic              mem_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic pop_s, push_s, push_ok_s, head_last_s, push_last_s;

  assign pop_s       = (count_q != CNT_ZERO) && out_ready;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO
  // still accepts a push when the consumer is taking the head.
  assign push_ok_s   = (count_q != FIFO_FULL) || pop_s;
  assign head_last_s = mem_last_q[rd_ptr_q];
  assign push_last_s = (remaining_q == ADDR_ONE);

  // Next-state logic for the load sequencer
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    push_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (word_count != ADDR_ZERO) begin
            addr_d      = base_addr;
            remaining_d = word_count;
            wait_d      = 4'd0;
            state_d     = S_ACCESS;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          if (push_ok_s) begin
            push_s = 1'b1;
          end else begin
            state_d = S_STALL;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_STALL: begin
        // Wait states were already served; sample as soon as there is room.
        if (push_ok_s) begin
          push_s = 1'b1;
        end else begin
          state_d = S_STALL;
        end
      end
      S_DRAIN: begin
        if (pop_s && head_last_s) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Every sample advances the block pointer and chooses the next access.
    if (push_s) begin
      addr_d      = addr_q + ADDR_ONE;
      remaining_d = remaining_q - ADDR_ONE;
      wait_d      = 4'd0;
      state_d     = push_last_s ? S_DRAIN : S_ACCESS;
    end else begin
      addr_d = addr_d;
    end
  end

  // Sequencer registers and registered pin/status outputs derived from next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= ADDR_ZERO;
      remaining_q <= ADDR_ZERO;
      wait_q      <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ctrl_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      busy_q      <= (state_d == S_ACCESS) || (state_d == S_STALL) || (state_d == S_DRAIN);
      done_q      <= (state_d == S_FIN);
      ctrl_n_q    <= !((state_d == S_ACCESS) || (state_d == S_STALL));
    end
  end

  // Output FIFO: write sampled SRAM words, advance read side on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= {DATA_W{1'b0}};
        mem_last_q[i] <= 1'b0;
      end
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_data_q[wr_ptr_q] <= sram_dq_in;
        mem_last_q[wr_ptr_q] <= push_last_s;
        wr_ptr_q             <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ctrl_n_q;
  assign sram_oe_n = ctrl_n_q;
  assign sram_lb_n = ctrl_n_q;
  assign sram_ub_n = ctrl_n_q;
  assign sram_we_n = 1'b1;
  assign out_valid = (count_q != CNT_ZERO);
  assign out_data  = mem_data_q[rd_ptr_q];
  assign out_last  = out_valid && head_last_s;

endmodule
